// File: rtl/cdc_pkg.sv
// cdc_pkg: shared widths and state type for the CDC serial link TX/RX ends
package cdc_pkg;
  localparam int MAX_BITS = 300;
  localparam int LEN_W = 9;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} tx_state_t;
endpackage

// File: rtl/cdc_tx_serializer.sv
// cdc_tx_serializer: loads a word and length, shifts it out LSB-first one bit per TXReady edge, pulses done
module cdc_tx_serializer #(
  parameter int MAX_BITS = cdc_pkg::MAX_BITS,
  parameter int LEN_W = cdc_pkg::LEN_W
) (
  input  logic                TXClk,
  input  logic                reset,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [MAX_BITS-1:0] load_word,
  input  logic [LEN_W-1:0]    load_len,
  input  logic                TXReady,
  output logic                TXData,
  output logic                busy,
  output logic                done,
  output logic [LEN_W-1:0]    TXbitCtr
);
  import cdc_pkg::*;
  tx_state_t r_state, w_next;
  logic [MAX_BITS-1:0] r_shift, w_mask;
  logic [LEN_W-1:0] r_rem, r_ctr, w_len;
  logic w_accept, w_step;
  always_comb begin
    w_len = (load_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : load_len;
    w_mask = ~({MAX_BITS{1'b1}} << w_len);
    w_accept = load_valid && r_state == IDLE;
    w_step = r_state == SHIFT && TXReady;
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? ((w_len == '0) ? DONE : SHIFT) : IDLE;
      SHIFT:   w_next = (w_step && r_rem == LEN_W'(1)) ? DONE : SHIFT;
      default: w_next = IDLE;
    endcase
    load_ready = r_state == IDLE;
    busy = r_state == SHIFT;
    done = r_state == DONE;
    TXData = r_shift[0];
    TXbitCtr = r_ctr;
  end
  always_ff @(posedge TXClk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Capture is masked to the effective length so the register drains to all-zero and TXData reads 0 after the last bit.
  always_ff @(posedge TXClk) begin
    if (reset) begin
      r_shift <= '0;
      r_rem <= '0;
      r_ctr <= '0;
    end else if (w_accept) begin
      r_shift <= load_word & w_mask;
      r_rem <= w_len;
      r_ctr <= '0;
    end else if (w_step) begin
      r_shift <= r_shift >> 1;
      r_rem <= r_rem - LEN_W'(1);
      r_ctr <= r_ctr + LEN_W'(1);
    end
  end
endmodule

// File: tb/tb_cdc_tx_serializer.sv
// tb_cdc_tx_serializer: randomized self-checking bench against a bit-list model of the serializer
module tb_cdc_tx_serializer;
  import cdc_pkg::*;
  logic TXClk = 0, reset = 1, load_valid = 0, TXReady = 0;
  logic [MAX_BITS-1:0] load_word = '0;
  logic [LEN_W-1:0] load_len = '0;
  logic load_ready, TXData, busy, done;
  logic [LEN_W-1:0] TXbitCtr;
  int checks = 0, errors = 0, cyc = 0;
  always #5 TXClk = ~TXClk;
  always @(posedge TXClk) cyc++;
  cdc_tx_serializer dut (
    .TXClk(TXClk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_word(load_word), .load_len(load_len), .TXReady(TXReady), .TXData(TXData),
    .busy(busy), .done(done), .TXbitCtr(TXbitCtr)
  );
  function automatic logic [MAX_BITS-1:0] expect_word(input logic [MAX_BITS-1:0] w, input int l);
    logic [MAX_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < l; i++) r[i] = w[i];
    return r;
  endfunction
  function automatic logic [MAX_BITS-1:0] rand_word();
    logic [MAX_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r = (r << 32) | MAX_BITS'($urandom());
    return r;
  endfunction
  // mode: 0 ready always, 1 toggle 1,0,1,0, 2 random, 3 never ready
  task automatic send(input logic [MAX_BITS-1:0] w, input int len, input int mode, input bit inject, input logic [MAX_BITS-1:0] alt);
    logic [MAX_BITS-1:0] got, exp;
    int n, k, l;
    bit seen, stall_bad, ready_bad, prev_stall;
    logic prev_d;
    got = '0; n = 0; k = 0; seen = 0; stall_bad = 0; ready_bad = 0; prev_stall = 0; prev_d = 0;
    l = len > MAX_BITS ? MAX_BITS : len;
    exp = expect_word(w, l);
    checks++;
    if (load_ready !== 1'b1) begin errors++; $display("FAIL load_ready_idle got %b want 1", load_ready); end
    load_valid = 1; load_word = w; load_len = LEN_W'(len); TXReady = 0;
    @(negedge TXClk);
    load_valid = inject; load_word = alt; load_len = LEN_W'($urandom_range(1, 300));
    while (!seen && k < 4000) begin
      k++;
      if (done === 1'b1) seen = 1;
      else begin
        if (load_ready !== 1'b0) ready_bad = 1;
        if (prev_stall && TXData !== prev_d) stall_bad = 1;
        TXReady = mode == 0 ? 1'b1 : mode == 1 ? (k % 2 == 1) : mode == 2 ? 1'($urandom()) : 1'b0;
        if (busy === 1'b1 && TXReady && n < MAX_BITS) begin got[n] = TXData; n++; end
        prev_stall = busy === 1'b1 && !TXReady;
        prev_d = TXData;
        @(negedge TXClk);
      end
    end
    load_valid = 0;
    checks++;
    if (!seen) begin errors++; $display("FAIL done_timeout len %0d cycles %0d", len, k); end
    if (mode == 0) begin
      checks++;
      if (k != l + 1) begin errors++; $display("FAIL done_latency got %0d want %0d", k, l + 1); end
    end
    checks++;
    if (n != l) begin errors++; $display("FAIL bit_count got %0d want %0d", n, l); end
    checks++;
    if (got !== exp) begin errors++; $display("FAIL word got %h want %h", got, exp); end
    checks++;
    if (stall_bad || ready_bad) begin errors++; $display("FAIL hold stall_changed %b load_ready_high %b want 0 0", stall_bad, ready_bad); end
    checks++;
    if (TXData !== 1'b0) begin errors++; $display("FAIL txdata_done got %b want 0", TXData); end
    @(negedge TXClk);
    checks++;
    if (done !== 1'b0 || TXData !== 1'b0 || load_ready !== 1'b1) begin
      errors++; $display("FAIL after_done done %b txdata %b load_ready %b want 0 0 1", done, TXData, load_ready);
    end
    checks++;
    if (TXbitCtr !== LEN_W'(l)) begin errors++; $display("FAIL bitctr got %0d want %0d", TXbitCtr, l); end
  endtask
  task automatic test_reset;
    checks++;
    if (load_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || TXData !== 1'b0 || TXbitCtr !== '0) begin
      errors++;
      $display("FAIL reset ready %b busy %b done %b txdata %b ctr %0d want 1 0 0 0 0", load_ready, busy, done, TXData, TXbitCtr);
    end
  endtask
  task automatic test_deadbeef;
    send(MAX_BITS'(32'hdeadbeef), 32, 0, 0, '0);
  endtask
  task automatic test_coffee_toggle;
    send(MAX_BITS'(24'hc0ffee) | (MAX_BITS'(8'hff) << 24), 24, 1, 0, '0);
  endtask
  task automatic test_long;
    send(MAX_BITS'(260'h31415926535897932384626433832795028841971693993751058209749445923), 260, 0, 0, '0);
  endtask
  task automatic test_reset_mid;
    bit d;
    d = 0;
    load_valid = 1; load_word = rand_word(); load_len = 32; TXReady = 1;
    @(negedge TXClk);
    load_valid = 0;
    for (int i = 0; i < 10; i++) begin if (done === 1'b1) d = 1; @(negedge TXClk); end
    reset = 1;
    @(negedge TXClk);
    reset = 0;
    checks++;
    if (busy !== 1'b0 || TXData !== 1'b0 || TXbitCtr !== '0 || load_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid busy %b txdata %b ctr %0d ready %b done %b want 0 0 0 1 0", busy, TXData, TXbitCtr, load_ready, done);
    end
    for (int i = 0; i < 3; i++) begin if (done === 1'b1) d = 1; @(negedge TXClk); end
    checks++;
    if (d) begin errors++; $display("FAIL reset_mid_done got 1 want 0"); end
    send(MAX_BITS'(24'hc0ffee), 24, 0, 0, '0);
  endtask
  task automatic test_len_bounds;
    send(rand_word(), 0, 3, 0, '0);
    send(rand_word(), 400, 2, 0, '0);
    send(rand_word(), 300, 0, 0, '0);
    send(rand_word(), 1, 2, 0, '0);
  endtask
  task automatic test_ignore_load;
    send(rand_word(), 48, 2, 1, rand_word());
  endtask
  task automatic test_back_to_back;
    int c0, l1, l2;
    l1 = $urandom_range(1, 40);
    l2 = $urandom_range(1, 40);
    c0 = cyc;
    send(rand_word(), l1, 0, 0, '0);
    send(rand_word(), l2, 0, 0, '0);
    checks++;
    if (cyc - c0 != l1 + l2 + 4) begin errors++; $display("FAIL b2b_cycles got %0d want %0d", cyc - c0, l1 + l2 + 4); end
  endtask
  task automatic test_random;
    for (int i = 0; i < 12; i++) send(rand_word(), $urandom_range(0, 320), $urandom_range(0, 2), 1'($urandom()), rand_word());
  endtask
  initial begin
    repeat (2) @(negedge TXClk);
    load_valid = 1; load_word = rand_word(); load_len = 5;
    @(negedge TXClk);
    test_reset;
    load_valid = 0;
    reset = 0;
    @(negedge TXClk);
    test_reset;
    test_deadbeef;
    test_coffee_toggle;
    test_long;
    test_reset_mid;
    test_len_bounds;
    test_ignore_load;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdc_tx_serializer.md
Name: cdc_tx_serializer

Overview:
- TXClk-domain source for the CDC serial link: accepts one parallel word plus bit length, then presents it LSB-first on TXData to the CDC block.
- Advances one bit per TXClk edge on which the CDC block asserts TXReady.
- Signals completion with a one-cycle pulse.
- Replaces the behavioural word-feeding logic currently embedded in simulation so the transmit end is synthesizable.

Parameters:
- MAX_BITS, 300, widest word accepted (bits).
- LEN_W, 9, width of length and bit counter fields; must satisfy 2**LEN_W > MAX_BITS.

Ports:
- TXClk  in  1  transmit clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset, sampled on TXClk rising edge.
- load_valid  in  1  request to start sending load_word.
- load_ready  out  1  high only in IDLE; a load is accepted when load_valid && load_ready.
- load_word  in  MAX_BITS  word to send, bit 0 first.
- load_len  in  LEN_W  number of bits to send.
- TXReady  in  1  from CDC block; current TXData is consumed at this edge.
- TXData  out  1  current bit to the CDC block.
- busy  out  1  high in SHIFT.
- done  out  1  one-cycle pulse after the last bit is consumed.
- TXbitCtr  out  LEN_W  bits consumed so far in the current word.

Behaviour:
- Reset (synchronous): state=IDLE, shift register=0, remaining=0, TXbitCtr=0, TXData=0, busy=0, done=0, load_ready=1. Reset overrides every other input in the same cycle.
- Reset mid-word: current word is discarded and no done pulse is produced.
- TXData is always the LSB of the registered shift register (no combinational path from inputs); it is 0 in IDLE.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - load_ready=1.
  - On load_valid, effective length L = min(load_len, MAX_BITS).
  - If L>0: capture load_word into the shift register, remaining=L, TXbitCtr=0, go to SHIFT. TXData shows bit 0 on the cycle after acceptance.
  - If L==0: go directly to DONE with nothing shifted.
- SHIFT:
  - On an edge with TXReady=1: shift register >>1 (zero fill), remaining-1, TXbitCtr+1.
  - If remaining was 1, go to DONE.
  - TXReady=0: hold all state; TXData stable for any stall length.
- DONE:
  - done=1 for exactly one cycle; TXData=0; then go to IDLE.
  - TXbitCtr holds its final value until the next accepted load.
- load_valid is ignored outside IDLE; the word is not queued.
- Bits above L in load_word are irrelevant: the shift register is masked to L bits at capture. After the last bit, TXData reads 0, never stale data.
- Back-to-back: earliest re-load is the cycle after done. Minimum per-word overhead is 2 cycles (accept, DONE).
- TXReady is assumed synchronous to TXClk; this block does no synchronization of its own.

Decomposition:
- Package cdc_pkg: MAX_BITS and LEN_W defaults; enum tx_state_t {IDLE, SHIFT, DONE}.
- The same package is to be reused by the future RX-side deserializer.
- No sub-module: shift register, counter and FSM fit in one module of about 150 lines.

Test Plan:
- Load 0xdeadbeef, len 32, TXReady held 1 → TXData sequence 1,1,1,1,0,1,1,1,… (LSB-first). done pulses once 33 cycles after acceptance (32 bits + DONE). TXbitCtr=32.
- Load 0xc0ffee, len 24, TXReady toggling 1,0,1,0 → each bit is held through its 0 cycles. Collected bits equal 0xc0ffee. TXbitCtr=24. No extra bits.
- Load the 260-bit constant 0x31415926535897932384626433832795028841971693993751058209749445923, len 260 → reassembled word matches exactly. TXData=0 after done.
- Assert reset on bit 10 of a 32-bit word → next cycle state=IDLE, TXData=0, TXbitCtr=0, no done pulse. A following load of 0xc0ffee transmits cleanly.
- Load with len 0 → done pulses the next cycle and TXReady is never needed. Load with len 400 → exactly 300 bits sent.
- Assert load_valid during SHIFT with a different word → ignored. Original word completes unaltered; load_ready=0 throughout.
